// File: rtl/aes_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : aes_pkg                                                      |
// | Description : Shared AES-128 constants, FSM state type and GF(2^8) helpers.|
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package aes_pkg;

  localparam int AES_NR    = 10;
  localparam int AES_BLK_W = 128;

  localparam logic [7:0] AES_RCON [AES_NR] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } aes_fsm_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Inverse as b^254 (b^2 * b^4 * ... * b^128), then the FIPS-197 affine map.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = b;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_iter_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : aes_iter_ctrl_if                                             |
// | Description : Plaintext/key input and ciphertext output valid/ready bus.   |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
interface aes_iter_ctrl_if;
  import aes_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [AES_BLK_W-1:0] in_data;
  logic [AES_BLK_W-1:0] in_key;
  logic                 out_valid;
  logic                 out_ready;
  logic [AES_BLK_W-1:0] out_data;

  modport master (
    output in_valid, in_data, in_key, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_key, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface
`default_nettype wire

// File: rtl/aes_round_comb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : aes_round_comb                                               |
// | Description : One combinational AES round; MixColumns bypassed on final.   |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module aes_round_comb
  import aes_pkg::*;
(
  input  logic [AES_BLK_W-1:0] state_in,
  input  logic [AES_BLK_W-1:0] round_key,
  input  logic                 final_rnd,
  output logic [AES_BLK_W-1:0] state_out
);

  logic [7:0] w_sb [16];
  logic [7:0] w_sr [16];
  logic [7:0] w_mc [16];

  for (genvar i = 0; i < 16; i++) begin : g_sbox
    assign w_sb[i] = sbox(state_in[AES_BLK_W-1-8*i -: 8]);
  end

  // Byte index is row + 4*col; row r rotates left by r columns.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        w_sr[r + 4*c] = w_sb[r + 4*((c + r) % 4)];
      end
    end
  end

  always_comb begin
    for (int c = 0; c < 4; c++) begin
      w_mc[4*c+0] = xtime(w_sr[4*c]) ^ xtime(w_sr[4*c+1]) ^ w_sr[4*c+1] ^
                    w_sr[4*c+2] ^ w_sr[4*c+3];
      w_mc[4*c+1] = w_sr[4*c] ^ xtime(w_sr[4*c+1]) ^ xtime(w_sr[4*c+2]) ^
                    w_sr[4*c+2] ^ w_sr[4*c+3];
      w_mc[4*c+2] = w_sr[4*c] ^ w_sr[4*c+1] ^ xtime(w_sr[4*c+2]) ^
                    xtime(w_sr[4*c+3]) ^ w_sr[4*c+3];
      w_mc[4*c+3] = xtime(w_sr[4*c]) ^ w_sr[4*c] ^ w_sr[4*c+1] ^
                    w_sr[4*c+2] ^ xtime(w_sr[4*c+3]);
    end
  end

  always_comb begin
    state_out = '0;
    for (int i = 0; i < 16; i++) begin
      state_out[AES_BLK_W-1-8*i -: 8] = (final_rnd ? w_sr[i] : w_mc[i]) ^
                                        round_key[AES_BLK_W-1-8*i -: 8];
    end
  end

endmodule
`default_nettype wire

// File: rtl/aes_iter_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : aes_iter_ctrl                                                |
// | Description : Iterative AES-128 encryptor, one round + key step per clock. |
// |               AES_BLK_CNT_EN adds the wrapping blk_cnt completion counter. |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module aes_iter_ctrl
  import aes_pkg::*;
#(
  parameter int NR = AES_NR
`ifdef AES_BLK_CNT_EN
  ,
  parameter int CNT_W = 32
`endif
) (
  input  logic           clk,
  input  logic           rst_n,
  aes_iter_ctrl_if.slave bus,
  output logic           busy
`ifdef AES_BLK_CNT_EN
  ,
  output logic [CNT_W-1:0] blk_cnt
`endif
);

  aes_fsm_e             r_fsm, w_fsm_nxt;
  logic [3:0]           r_rnd, w_rnd_nxt;
  logic [AES_BLK_W-1:0] r_state, w_state_nxt;
  logic [AES_BLK_W-1:0] r_key, w_key_nxt;
  logic [AES_BLK_W-1:0] r_out_data, w_out_data_nxt;
  logic                 r_out_valid, w_out_valid_nxt;

  logic [7:0]           w_rcon;
  logic [31:0]          w_rot, w_sub, w_nk0, w_nk1, w_nk2, w_nk3;
  logic [AES_BLK_W-1:0] w_nk, w_round;
  logic                 w_final, w_xfer;

  always_comb begin
    w_rcon = 8'h00;
    for (int i = 0; i < AES_NR; i++) begin
      if (r_rnd == 4'(i + 1)) w_rcon = AES_RCON[i];
    end
  end

  // Next round key from the current one: w[i] = w[i-4] ^ w[i-1] chain.
  assign w_rot = {r_key[23:0], r_key[31:24]};
  assign w_sub = {sbox(w_rot[31:24]), sbox(w_rot[23:16]),
                  sbox(w_rot[15:8]),  sbox(w_rot[7:0])} ^ {w_rcon, 24'h000000};
  assign w_nk0 = r_key[127:96] ^ w_sub;
  assign w_nk1 = r_key[95:64]  ^ w_nk0;
  assign w_nk2 = r_key[63:32]  ^ w_nk1;
  assign w_nk3 = r_key[31:0]   ^ w_nk2;
  assign w_nk  = {w_nk0, w_nk1, w_nk2, w_nk3};

  assign w_final = (r_rnd == 4'(NR));
  assign w_xfer  = (r_fsm == DONE) && r_out_valid && bus.out_ready;

  aes_round_comb u_round (
    .state_in  (r_state),
    .round_key (w_nk),
    .final_rnd (w_final),
    .state_out (w_round)
  );

  always_comb begin
    w_fsm_nxt       = r_fsm;
    w_rnd_nxt       = r_rnd;
    w_state_nxt     = r_state;
    w_key_nxt       = r_key;
    w_out_data_nxt  = r_out_data;
    w_out_valid_nxt = r_out_valid;
    case (r_fsm)
      IDLE: begin
        if (bus.in_valid) begin
          w_state_nxt = bus.in_data ^ bus.in_key;
          w_key_nxt   = bus.in_key;
          w_rnd_nxt   = 4'd1;
          w_fsm_nxt   = RUN;
        end
      end
      RUN: begin
        if (r_rnd == 4'd0 || r_rnd > 4'(NR)) begin
          w_rnd_nxt = 4'd0;
          w_fsm_nxt = IDLE;
        end else begin
          w_key_nxt   = w_nk;
          w_state_nxt = w_round;
          w_rnd_nxt   = r_rnd + 4'd1;
          if (w_final) begin
            w_out_data_nxt  = w_round;
            w_out_valid_nxt = 1'b1;
            w_fsm_nxt       = DONE;
          end
        end
      end
      DONE: begin
        if (w_xfer) begin
          w_out_valid_nxt = 1'b0;
          w_fsm_nxt       = IDLE;
        end
      end
      default: w_fsm_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm       <= IDLE;
      r_rnd       <= 4'd0;
      r_state     <= '0;
      r_key       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_fsm       <= w_fsm_nxt;
      r_rnd       <= w_rnd_nxt;
      r_state     <= w_state_nxt;
      r_key       <= w_key_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

`ifdef AES_BLK_CNT_EN
  logic [CNT_W-1:0] r_blk_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_blk_cnt <= '0;
    else if (w_xfer) r_blk_cnt <= r_blk_cnt + 1'b1;
  end

  assign blk_cnt = r_blk_cnt;
`endif

  assign bus.in_ready  = (r_fsm == IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign busy          = (r_fsm == RUN) || (r_fsm == DONE);

endmodule
`default_nettype wire

// File: tb/tb_aes_iter_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_aes_iter_ctrl                                             |
// | Description : Directed scoreboard bench for aes_iter_ctrl.                 |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_aes_iter_ctrl;
  import aes_pkg::*;

  localparam int TB_CNT_W = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
`ifdef AES_BLK_CNT_EN
  logic [TB_CNT_W-1:0] blk_cnt;
`endif

  aes_iter_ctrl_if bus ();

  aes_iter_ctrl #(
    .NR    (AES_NR)
`ifdef AES_BLK_CNT_EN
    ,
    .CNT_W (TB_CNT_W)
`endif
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
`ifdef AES_BLK_CNT_EN
    ,
    .blk_cnt (blk_cnt)
`endif
  );

  always #5 clk = ~clk;

  int           n_vec  = 0;
  int           n_err  = 0;
  int           cyc    = 0;
  int           n_done = 0;
  logic [127:0] sb [$];
  int           acc_q [$];
  logic [127:0] cur_exp;
  bit           prev_ov = 1'b0;
  logic [127:0] pt_v  [5];
  logic [127:0] key_v [5];
  logic [127:0] ct_v  [5];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int k);
    bus.in_data = pt_v[k];
    bus.in_key  = key_v[k];
    cur_exp     = ct_v[k];
  endtask

  // Called at a falling edge: log handshakes that the next rising edge completes.
  task automatic step(output bit acc);
    acc = 1'b0;
    if (bus.in_valid && bus.in_ready) begin
      sb.push_back(cur_exp);
      acc_q.push_back(cyc);
      acc = 1'b1;
    end
    if (bus.out_valid && !prev_ov) begin
      if (acc_q.size() > 0) chk("latency", 128'(cyc - acc_q.pop_front()), 128'd11);
      else                  chk("spurious_out_valid", bus.out_valid, 128'd0);
    end
    if (bus.out_valid && bus.out_ready) begin
      if (sb.size() > 0) chk("ciphertext", bus.out_data, sb.pop_front());
      else               chk("unexpected_output", bus.out_valid, 128'd0);
      n_done++;
    end
    prev_ov = bus.out_valid;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain(input string tag, input int budget);
    bit a;
    for (int i = 0; i < budget && sb.size() != 0; i++) step(a);
    chk({tag, "_drained"}, 128'(sb.size()), 128'd0);
  endtask

  initial begin
    bit a;
    int idx;
    int last_acc;
    int base;
    bit c3;

    pt_v[0] = 128'h00112233445566778899aabbccddeeff; key_v[0] = 128'h000102030405060708090a0b0c0d0e0f;
    ct_v[0] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    pt_v[1] = 128'h3243f6a8885a308d313198a2e0370734; key_v[1] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    ct_v[1] = 128'h3925841d02dc09fbdc118597196a0b32;
    pt_v[2] = 128'h6bc1bee22e409f96e93d7e117393172a; key_v[2] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    ct_v[2] = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    pt_v[3] = 128'hae2d8a571e03ac9c9eb76fac45af8e51; key_v[3] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    ct_v[3] = 128'hf5d3d58503b9699de785895a96fdbaaf;
    pt_v[4] = 128'h30c81c46a35ce411e5fbc1191a0a52ef; key_v[4] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    ct_v[4] = 128'h43b1cd7f598ece23881b00e3ed030688;

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    drive(0);

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 128'd0);
    chk("rst_busy", busy, 128'd0);
    chk("rst_out_data", bus.out_data, 128'd0);
`ifdef AES_BLK_CNT_EN
    chk("rst_blk_cnt", blk_cnt, 128'd0);
`endif
    rst_n = 1'b1;
    step(a);
    chk("idle_in_ready", bus.in_ready, 128'd1);

    // FIPS-197 C.1 with out_ready already high
    drive(0);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    step(a);
    chk("c1_accept", a, 128'd1);
    bus.in_valid = 1'b0;
    drain("c1", 40);
    chk("c1_idle_in_ready", bus.in_ready, 128'd1);

    // App. B with in_valid held high and 20 cycles of backpressure
    drive(1);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    step(a);
    for (int i = 0; i < 10; i++) begin
      chk("b_run_in_ready", bus.in_ready, 128'd0);
      chk("b_run_busy", busy, 128'd1);
      step(a);
    end
    for (int i = 0; i < 20; i++) begin
      chk("b_hold_out_valid", bus.out_valid, 128'd1);
      chk("b_hold_out_data", bus.out_data, ct_v[1]);
      chk("b_hold_in_ready", bus.in_ready, 128'd0);
      step(a);
    end
    chk("b_single_capture", 128'(sb.size()), 128'd1);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step(a);
    chk("b_after_out_valid", bus.out_valid, 128'd0);
    chk("b_after_in_ready", bus.in_ready, 128'd1);
    chk("b_after_busy", busy, 128'd0);
    chk("b_out_data_kept", bus.out_data, ct_v[1]);
    chk("b_drained", 128'(sb.size()), 128'd0);

    // Asynchronous reset while round 5 is pending
    drive(2);
    bus.in_valid = 1'b1;
    step(a);
    bus.in_valid = 1'b0;
    repeat (4) step(a);
    chk("mid_busy_before_rst", busy, 128'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", bus.out_valid, 128'd0);
    chk("mid_rst_out_data", bus.out_data, 128'd0);
    chk("mid_rst_busy", busy, 128'd0);
    sb.delete();
    acc_q.delete();
    prev_ov = 1'b0;
    step(a);
    step(a);
    chk("mid_rst_hold_busy", busy, 128'd0);
    rst_n = 1'b1;
    step(a);
    drive(0);
    bus.in_valid = 1'b1;
    step(a);
    bus.in_valid = 1'b0;
    drain("post_rst_c1", 40);

    // Back-to-back: five blocks, in_valid and out_ready held high
    rst_n = 1'b0;
    step(a);
    rst_n = 1'b1;
    step(a);
    idx      = 0;
    last_acc = 0;
    base     = n_done;
    c3       = 1'b0;
    drive(0);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 100 && !(idx == 5 && sb.size() == 0); i++) begin
      step(a);
      if (a) begin
        if (idx > 0) chk("b2b_spacing", 128'(cyc - 1 - last_acc), 128'd12);
        last_acc = cyc - 1;
        idx++;
        if (idx < 5) drive(idx);
        else         bus.in_valid = 1'b0;
      end
`ifdef AES_BLK_CNT_EN
      if (n_done - base == 3 && !c3) begin
        chk("blk_cnt_3", blk_cnt, 128'd3);
        c3 = 1'b1;
      end
`endif
    end
    chk("b2b_accepts", 128'(idx), 128'd5);
    chk("b2b_drained", 128'(sb.size()), 128'd0);
`ifdef AES_BLK_CNT_EN
    chk("blk_cnt_wrap", blk_cnt, 128'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
